// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic [1:0]  owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_be, m_addr, m_wdata, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_be, m_addr, m_wdata, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one memory port with transfer timeout
// MEM_ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise data beats fetch.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_e;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_elig, d_elig, i_win, d_win;

  // A requester is still holding its request during its own ack cycle; mask it.
  assign i_elig = bus.i_req & ~i_ack_q;
  assign d_elig = bus.d_req & ~d_ack_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  assign d_win    = d_elig & (~i_elig | ~last_d_q);
  assign last_d_d = (state_q == IDLE && (i_win || d_win)) ? d_win : last_d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_d_q <= 1'b1;
    else        last_d_q <= last_d_d;
  end
`else
  assign d_win = d_elig;
`endif
  assign i_win = i_elig & ~d_win;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d   = GNT_D;
          m_req_d   = 1'b1;
          cnt_d     = '0;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_be;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
        end else if (i_win) begin
          state_d   = GNT_I;
          m_req_d   = 1'b1;
          cnt_d     = '0;
          m_we_d    = 1'b0;
          m_be_d    = 4'hF;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        // m_ack takes precedence over a timeout landing in the same cycle
        if (bus.m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == GNT_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.m_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.m_rdata;
          end
        end else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          err_d   = 1'b1;
          if (state_q == GNT_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.err     = err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.owner   = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]  who;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  bus_t        exp_bus[$];
  resp_t       exp_resp[$];
  int          mem_dly_q[$];
  logic [31:0] mem_dat_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit mem_en = 1'b0;
  bit last_data = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_m_req"},   32'(bus.m_req), 0);
    chk({t, "_m_we"},    32'(bus.m_we), 0);
    chk({t, "_m_be"},    32'(bus.m_be), 0);
    chk({t, "_m_addr"},  bus.m_addr, 0);
    chk({t, "_m_wdata"}, bus.m_wdata, 0);
    chk({t, "_i_ack"},   32'(bus.i_ack), 0);
    chk({t, "_d_ack"},   32'(bus.d_ack), 0);
    chk({t, "_err"},     32'(bus.err), 0);
    chk({t, "_i_rdata"}, bus.i_rdata, 0);
    chk({t, "_d_rdata"}, bus.d_rdata, 0);
    chk({t, "_owner"},   32'(bus.owner), 0);
  endtask

  // Expected outcome of one granted transfer, derived from the memory delay chosen for it
  task automatic expect_xfer(input logic [1:0] who, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int dly, input logic [31:0] dat);
    bus_t  b;
    resp_t r;
    b.who = who; b.we = we; b.be = be; b.addr = addr; b.wdata = wdata;
    exp_bus.push_back(b);
    r.who = who;
    if (dly < TO) begin
      r.rdata = dat; r.err = 1'b0; r.lat = dly + 1;
    end else begin
      r.rdata = '0;  r.err = 1'b1; r.lat = TO;
    end
    exp_resp.push_back(r);
    mem_dly_q.push_back(dly);
    mem_dat_q.push_back(dat);
  endtask

  // mode: 1 fetch only, 2 data only, 3 both together
  task automatic run_scen(input int mode, input logic [31:0] ia, input logic dwe,
                          input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                          input int dli, input int dld, input logic [31:0] mi,
                          input logic [31:0] md, input bit hold);
    int order[$];
    int budget;
    bit i_act, d_act, i_drop, d_drop;
    if (mode == 3) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_data) begin order.push_back(1); order.push_back(2); end
      else           begin order.push_back(2); order.push_back(1); end
`else
      order.push_back(2); order.push_back(1);
`endif
    end else begin
      order.push_back(mode);
    end
    foreach (order[n]) begin
      if (order[n] == 1) expect_xfer(2'b01, 1'b0, 4'hF, ia, 32'h0, dli, mi);
      else               expect_xfer(2'b10, dwe, dbe, da, dwd, dld, md);
      last_data = (order[n] == 2);
    end

    @(posedge clk); #1;
    i_act = (mode != 2); d_act = (mode != 1); i_drop = 1'b0; d_drop = 1'b0;
    bus.i_addr = ia; bus.d_we = dwe; bus.d_be = dbe; bus.d_addr = da; bus.d_wdata = dwd;
    bus.i_req = i_act; bus.d_req = d_act;
    budget = 4 * (TO + 3);
    while ((i_act || d_act) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (i_drop) begin bus.i_req = 1'b0; i_act = 1'b0; i_drop = 1'b0; end
      else if (i_act && bus.i_ack) begin
        if (hold) i_drop = 1'b1;
        else begin bus.i_req = 1'b0; i_act = 1'b0; end
      end
      if (d_drop) begin bus.d_req = 1'b0; d_act = 1'b0; d_drop = 1'b0; end
      else if (d_act && bus.d_ack) begin
        if (hold) d_drop = 1'b1;
        else begin bus.d_req = 1'b0; d_act = 1'b0; end
      end
    end
    chk("req_completion", {30'b0, d_act, i_act}, 0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Memory responder: acks after the delay queued for each grant, random acks while idle
  initial begin : responder
    bit          m_act;
    int          m_cyc, m_dly;
    logic [31:0] m_dat;
    m_act = 1'b0; m_cyc = 0; m_dly = 0; m_dat = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        bus.m_ack = 1'b0; m_act = 1'b0;
      end else if (bus.m_req) begin
        if (!m_act) begin
          m_act = 1'b1; m_cyc = 0;
          if (mem_dly_q.size() > 0) begin
            m_dly = mem_dly_q.pop_front(); m_dat = mem_dat_q.pop_front();
          end else begin
            m_dly = 1000; m_dat = '0;
          end
        end
        bus.m_ack   = (m_cyc == m_dly);
        bus.m_rdata = (m_cyc == m_dly) ? m_dat : $urandom();
        m_cyc++;
      end else begin
        m_act = 1'b0;
        bus.m_ack   = ($urandom_range(0, 3) == 0);
        bus.m_rdata = $urandom();
      end
    end
  end

  initial begin : monitor
    bus_t  cur;
    resp_t r;
    bit    prev_req, have;
    int    rise;
    prev_req = 1'b0; have = 1'b0; rise = 0;
    cur = '{who: 2'b00, we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.m_req && !prev_req) begin
          if (exp_bus.size() == 0) begin
            chk("unexpected_grant", 32'(bus.owner), 0);
            have = 1'b0;
          end else begin
            cur = exp_bus.pop_front(); have = 1'b1; rise = cyc;
            chk("owner", 32'(bus.owner), 32'(cur.who));
            chk("m_we", 32'(bus.m_we), 32'(cur.we));
            chk("m_be", 32'(bus.m_be), 32'(cur.be));
            chk("m_addr", bus.m_addr, cur.addr);
            if (cur.who == 2'b10) chk("m_wdata", bus.m_wdata, cur.wdata);
          end
        end else if (bus.m_req && have) begin
          chk("m_stable", 32'(bus.m_addr === cur.addr && bus.m_we === cur.we &&
                               bus.m_be === cur.be &&
                               (cur.who != 2'b10 || bus.m_wdata === cur.wdata)), 1);
        end
        if (bus.i_ack || bus.d_ack) begin
          if (exp_resp.size() == 0) begin
            chk("unexpected_ack", {30'b0, bus.d_ack, bus.i_ack}, 0);
          end else begin
            r = exp_resp.pop_front();
            chk("ack_who", {30'b0, bus.d_ack, bus.i_ack}, 32'(r.who));
            chk("rdata", (r.who == 2'b01) ? bus.i_rdata : bus.d_rdata, r.rdata);
            chk("err", 32'(bus.err), 32'(r.err));
            chk("latency", 32'(cyc - rise), 32'(r.lat));
            chk("m_req_in_ack_cycle", 32'(bus.m_req), 0);
          end
        end else if (bus.err) begin
          chk("err_without_ack", 32'(bus.err), 0);
        end
      end
      prev_req = bus.m_req;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) reset = 1'b1;

    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 32'h100; bus.d_be = 4'hF;
    @(posedge clk); #1;
    chk("gnt_d_m_req", 32'(bus.m_req), 1);
    chk("gnt_d_owner", 32'(bus.owner), 2);
    @(negedge clk); #1 reset = 1'b0;
    #1 chk_reset("mid_gnt_d");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("release_m_req", 32'(bus.m_req), 1);
    chk("release_m_addr", bus.m_addr, 32'h100);
    bus.d_req = 1'b0; reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    last_data = 1'b1;
    mon_en = 1'b1; mem_en = 1'b1;

    run_scen(2, 32'h0, 1'b0, 4'hF, 32'h100, 32'h0, 0, 2, 32'h0, 32'hDEADBEEF, 1'b0);
    run_scen(2, 32'h0, 1'b1, 4'b0011, 32'h200, 32'h12345678, 0, 3, 32'h0, 32'hCAFEF00D, 1'b0);
    run_scen(1, 32'h400, 1'b0, 4'h0, 32'h0, 32'h0, 100, 0, 32'h55AA55AA, 32'h0, 1'b0);
    run_scen(2, 32'h0, 1'b0, 4'hF, 32'h300, 32'h0, 0, 100, 32'h0, 32'h13579BDF, 1'b1);
    repeat (3) run_scen(3, 32'h1000, 1'b0, 4'hF, 32'h2000, 32'h0, 0, 0, $urandom(), $urandom(), 1'b1);
    run_scen(1, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, 32'hA5A5A5A5, 32'h0, 1'b1);

    for (int k = 0; k < 150; k++) begin
      run_scen($urandom_range(1, 3), $urandom(), 1'($urandom()), 4'($urandom()), $urandom(),
               $urandom(), $urandom_range(0, 4), $urandom_range(0, 4), $urandom(), $urandom(),
               1'($urandom()));
    end

    repeat (5) @(posedge clk);
    chk("resp_queue_empty", 32'(exp_resp.size()), 0);
    chk("bus_queue_empty", 32'(exp_bus.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one external memory port between the instruction-fetch requester and the data (M-stage) requester of the five-stage pipeline. It produces the `inst_mem_ack`/`data_mem_ack` handshakes the datapath's hazard unit consumes to stall the pipeline. It registers each granted transfer onto the memory bus and waits a variable number of cycles for the memory's acknowledge. A timeout counter aborts hung transfers.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum wait cycles for `m_ack` before abort; range 1–65535.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `i_req` input 1: fetch request; held high until `i_ack`.
- `i_addr` input 32: fetch address.
- `i_rdata` output 32: fetched word, valid while `i_ack`.
- `i_ack` output 1: one-cycle fetch completion pulse.
- `d_req` input 1: data request; held high until `d_ack`.
- `d_we` input 1: 1 = store.
- `d_be` input 4: byte enables.
- `d_addr` input 32: data address.
- `d_wdata` input 32: store data.
- `d_rdata` output 32: load data, valid while `d_ack`.
- `d_ack` output 1: one-cycle data completion pulse.
- `err` output 1: high with `i_ack`/`d_ack` when the transfer timed out.
- `m_req` output 1: memory request.
- `m_we` output 1: memory write enable.
- `m_be` output 4: memory byte enables.
- `m_addr` output 32: memory address.
- `m_wdata` output 32: memory write data.
- `m_rdata` input 32: memory read data, valid with `m_ack`.
- `m_ack` input 1: memory completion, sampled on `clk`.
- `owner` output 2: 00 idle, 01 fetch, 10 data.

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Arbitrate among unmasked requests.
  - A requester whose ack is high this cycle is masked.
  - On a win, latch that requester's address, we, be and wdata into the `m_*` registers.
  - Set `m_req`=1 and clear the timeout counter.
  - Enter GNT_I or GNT_D.
  - Fetch grants always drive `m_we`=0 and `m_be`=1111.
- GNT_x with `m_ack`=1:
  - Clear `m_req`.
  - Capture `m_rdata` into `x_rdata`, including on stores.
  - Pulse `x_ack`; `err`=0.
  - Return to IDLE.
- GNT_x with `m_ack`=0:
  - Increment the counter (16 bit, saturating).
  - When the counter equals TIMEOUT−1 and `m_ack` is still low: clear `m_req`, set `x_rdata`=0, pulse `x_ack` and `err`, return to IDLE.
  - If `m_ack` and the timeout coincide, `m_ack` wins and `err`=0.
- `m_*` address, data, we and be hold stable for the whole GNT state.
- A requester that drops its request mid-grant is a protocol violation. The transfer still completes and the ack still pulses.
- `m_ack` received in IDLE is ignored.
- `owner` reflects the state.
- Arbitration priority is set by the configuration macro.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE. The following outputs are 0: `m_req`, `m_we`, `m_be`, `m_addr`, `m_wdata`, `i_ack`, `d_ack`, `err`, `i_rdata`, `d_rdata`, `owner`. Counter = 0; round-robin pointer = data.
- Reset asserted mid-transfer abandons the transfer; no ack is issued.
- Request high at edge n → `m_req` high after edge n+1.
- `m_ack` sampled high at edge k → `x_ack` high and `m_req` low after edge k.
- Minimum fetch-to-ack latency: 2 cycles when memory acks in its first request cycle.
- Back-to-back: the other requester may be granted in the ack cycle, giving `m_req` high in the cycle after ack. Peak rate is one transfer per 2 cycles.
- Timeout: ack/`err` pulse occurs exactly TIMEOUT cycles after `m_req` rises.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant goes to the requester not served last.
  - The pointer updates at each grant.
  - After reset, the first simultaneous grant goes to fetch.
- Undefined:
  - Fixed priority: data always wins over fetch.
  - No pointer register.
- A lone request is granted identically in both builds.

## Test plan
- Reset: `reset`=0 mid-GNT_D → all outputs 0 immediately, state IDLE; after release, `d_req` high → `m_req` high next cycle.
- Single load:
  - Stimulus: `d_req`=1, `d_addr`=0x100, memory acks 3 cycles after `m_req` with `m_rdata`=0xDEADBEEF.
  - Response: `d_ack` one cycle with `d_rdata`=0xDEADBEEF, `err`=0, `m_we`=0.
- Store:
  - Stimulus: `d_we`=1, `d_be`=0011, `d_wdata`=0x12345678, `d_addr`=0x200.
  - Response: `m_*` carry exactly those values and are stable until `m_ack`.
- Contention: `i_req` and `d_req` both high continuously, memory acks immediately.
  - With the macro: grants alternate I, D, I, D.
  - Without the macro: D granted first; I granted only after `d_req` drops.
- Timeout: TIMEOUT=4, fetch granted, `m_ack` never asserted → `i_ack`=1, `err`=1, `i_rdata`=0 exactly 4 cycles after `m_req` rose; `m_req` low afterward.
- Ack masking: requester holds its request one cycle into the ack cycle → no duplicate grant issued to it.
